// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: shared UART transmitter types and the bit-period helper.
package uart_transmitter_pkg;

    typedef logic [7:0] UartData_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UartTxState_t;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter; ticks on the last cycle of each bit and
// reloads with a stop-length period when long_i is set.
module uart_baud_tick #(
    parameter int unsigned CYCLES_PER_BIT = 868,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic long_i,
    output logic tick_o
);

    localparam int unsigned W = $clog2(STOP_BITS * CYCLES_PER_BIT);
    localparam logic [W-1:0] SHORT = W'(CYCLES_PER_BIT - 1);
    localparam logic [W-1:0] LONG  = W'(STOP_BITS * CYCLES_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = clr_i ? SHORT : !en_i ? cnt_q : tick_o ? (long_i ? LONG : SHORT) : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1/8N2 UART transmitter, LSB first, registered txd and uartBusy.
// Defining UART_PARITY_EN inserts a parity bit between the data and stop bits.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      uartStartSend,
    input  UartData_t uartDataToSend,
    output logic      uartBusy,
    output logic      txd
);

    localparam int unsigned CPB = cycles_per_bit(CLK_FREQ, BAUD_RATE);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_transmitter: CYCLES_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

`ifdef UART_PARITY_EN
    localparam logic PARITY_ODD = 1'b0;
    logic par_q, par_d;
`endif

    UartTxState_t state_q, state_d;
    UartData_t    shift_q, shift_d;
    logic [2:0]   bit_q, bit_d;
    logic         busy_q, busy_d;
    logic         txd_q, txd_d;
    logic         accept;
    logic         tick;

    uart_baud_tick #(
        .CYCLES_PER_BIT(CPB),
        .STOP_BITS     (STOP_BITS)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (busy_q),
        .long_i(state_d == STOP),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        txd_d   = txd_q;
        accept  = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (uartStartSend) begin
                accept  = 1'b1;
                state_d = START;
                shift_d = uartDataToSend;
                busy_d  = 1'b1;
                txd_d   = 1'b0;
`ifdef UART_PARITY_EN
                par_d   = ^uartDataToSend ^ PARITY_ODD;
`endif
            end
            START: if (tick) begin
                state_d = DATA;
                txd_d   = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = 3'd0;
            end
            DATA: if (tick) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = PARITY;
                    txd_d   = par_q;
`else
                    state_d = STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
`endif
            STOP: if (tick) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uartBusy = busy_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a line monitor decodes each frame on txd and
// checks it against the bytes queued by the stimulus (unit 0: 1 stop bit, unit 1: 2).
module tb_uart_transmitter;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       busy0, busy1, txd0, txd1;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];

    always #5 clk = ~clk;

    uart_transmitter #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .uartStartSend(start0), .uartDataToSend(data0),
        .uartBusy(busy0), .txd(txd0));

    uart_transmitter #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .uartStartSend(start1), .uartDataToSend(data1),
        .uartBusy(busy1), .txd(txd1));

    function automatic logic txd_of(input int u);
        return (u == 0) ? txd0 : txd1;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor(input int u, input int sb);
        logic        prev;
        logic [10:0] bits;
        logic [7:0]  exp;
        bit          steady, busy_ok, stop_ok, aborted;
        int          slots;
        prev  = 1'b1;
        slots = 9 + sb;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else if (prev && !txd_of(u)) begin
                bits = '0; steady = 1; busy_ok = 1; stop_ok = 1; aborted = 0;
                for (int k = 0; k < slots * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1;
                        break;
                    end
                    if (k % CPB == 0) bits[k / CPB] = txd_of(u);
                    else if (txd_of(u) !== bits[k / CPB]) steady = 0;
                    if (busy_of(u) !== 1'b1) busy_ok = 0;
                end
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    @(negedge clk);
                    check($sformatf("u%0d busy_falls_at_frame_end", u), busy_of(u), 0);
                    for (int s = 0; s < sb; s++) if (bits[9 + s] !== 1'b1) stop_ok = 0;
                    if ((u == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL u%0d unexpected_frame: got byte %0h, expected no frame", u, bits[8:1]);
                    end else begin
                        exp = (u == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                        check($sformatf("u%0d data", u), bits[8:1], exp);
                        check($sformatf("u%0d start_bit", u), bits[0], 0);
                        check($sformatf("u%0d stop_bits", u), stop_ok, 1);
                        check($sformatf("u%0d bits_steady_%0d_cycles", u, CPB), steady, 1);
                        check($sformatf("u%0d busy_whole_frame", u), busy_ok, 1);
                    end
                    prev = txd_of(u);
                end
            end else begin
                prev = txd_of(u);
            end
        end
    endtask

    initial monitor(0, 1);
    initial monitor(1, 2);

    // mode 0: expect ignore, 1: accept and expect frame, 2: accept, frame will be aborted
    task automatic send(input int u, input logic [7:0] d, input int mode);
        if (u == 0) begin start0 = 1'b1; data0 = d; end
        else        begin start1 = 1'b1; data1 = d; end
        if (mode == 1) begin
            if (u == 0) exp0_q.push_back(d);
            else        exp1_q.push_back(d);
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (mode != 0) begin
            check($sformatf("u%0d busy_after_accept", u), busy_of(u), 1);
            check($sformatf("u%0d txd_start_after_accept", u), txd_of(u), 0);
        end
    endtask

    task automatic wait_idle(input int u);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy_of(u)) done = 1;
        end
        if (!done) check($sformatf("u%0d wait_idle_timeout", u), busy_of(u), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_txd0", txd0, 1);
        check("reset_busy0", busy0, 0);
        check("reset_txd1", txd1, 1);
        check("reset_busy1", busy1, 0);
        rst = 1'b1;
        @(negedge clk);
        send(0, 8'h41, 1);
        wait_idle(0);
        @(negedge clk);
        send(0, 8'h55, 1);
        wait_idle(0);
        send(0, 8'hAA, 1);
        wait_idle(0);
        @(negedge clk);
        send(0, 8'h99, 1);
        repeat (30) @(negedge clk);
        send(0, 8'hFF, 0);
        check("busy_held_through_ignored_start", busy0, 1);
        wait_idle(0);
        @(negedge clk);
        send(0, 8'h33, 1);
        repeat (100) @(negedge clk);
        check("busy_in_last_frame_cycle", busy0, 1);
        start0 = 1'b1;
        data0  = 8'hEE;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("start_on_frame_end_ignored_busy", busy0, 0);
        repeat (5) @(negedge clk);
        check("start_on_frame_end_ignored_txd", txd0, 1);
        @(negedge clk);
        send(0, 8'hC3, 2);
        repeat (35) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_txd", txd0, 1);
        check("async_reset_busy", busy0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle_txd", txd0, 1);
        check("post_reset_idle_busy", busy0, 0);
        send(0, 8'h0D, 1);
        wait_idle(0);
        @(negedge clk);
        send(1, 8'h00, 1);
        wait_idle(1);
        @(negedge clk);
        send(1, 8'hA5, 1);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("u0 frames_outstanding", exp0_q.size(), 0);
        check("u1 frames_outstanding", exp1_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
